warp_scheduler: RTL

Round-robin warp scheduler for one compute core. It owns the shared per-core pipeline and grants it to one warp at a time. It drives the one-hot `warp_enable` vector and the broadcast `warp_state` consumed by each warp's scalar and vector register files, fetcher, decoder and LSU. It sequences each granted warp through one full instruction, retires warps that decode a RET, and signals kernel completion.

---
 rtl/warp_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: grants the shared core pipeline to one warp at a time and
// sequences it through FETCH..UPDATE. Optional perf counters behind `WARP_SCHED_PERF_EN.

package warp_sched_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;
endpackage

module warp_scheduler
  import warp_sched_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WARP_ID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_WARPS-1:0] warp_active_mask,
  input  logic                 fetch_done,
  input  logic                 decoded_ret,
  input  logic                 mem_pending,
  output logic [NUM_WARPS-1:0] warp_enable,
  output warp_state_t          warp_state,
  output logic [WARP_ID_W-1:0] cur_warp,
  output logic                 busy,
  output logic                 done
`ifdef WARP_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_instr
`endif
);

  warp_state_t          state_q, state_d;
  logic [WARP_ID_W-1:0] cur_q, cur_d;
  logic [NUM_WARPS-1:0] fin_q, fin_d;
  logic [NUM_WARPS-1:0] enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rotate;
  logic [WARP_ID_W:0]   pick;

  // Next unfinished warp after cur, wrapping; cur itself is considered last.
  // Result is {found, index}.
  function automatic logic [WARP_ID_W:0] rotate_pick(
    input logic [NUM_WARPS-1:0] fin,
    input logic [WARP_ID_W-1:0] cur
  );
    logic [WARP_ID_W:0] r;
    int                 idx;
    r = '0;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      idx = int'(cur) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!fin[WARP_ID_W'(idx)]) r = {1'b1, WARP_ID_W'(idx)};
    end
    return r;
  endfunction

  function automatic logic [WARP_ID_W:0] first_active(input logic [NUM_WARPS-1:0] mask);
    logic [WARP_ID_W:0] r;
    r = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, WARP_ID_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    fin_d   = fin_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rotate  = 1'b0;
    pick    = '0;

    case (state_q)
      WARP_IDLE, WARP_DONE: begin
        // A launch from DONE clears done and relaunches in one transition.
        if (start) begin
          fin_d = ~warp_active_mask;
          pick  = first_active(warp_active_mask);
          if (pick[WARP_ID_W]) begin
            state_d = WARP_FETCH;
            cur_d   = pick[WARP_ID_W-1:0];
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end else begin
            state_d = WARP_DONE;
            cur_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      WARP_FETCH: begin
        if (fetch_done) state_d = WARP_FETCH == WARP_FETCH ? WARP_DECODE : WARP_FETCH;
      end
      WARP_DECODE: begin
        if (decoded_ret) begin
          fin_d[cur_q] = 1'b1;
          rotate       = 1'b1;
        end else begin
          state_d = WARP_REQUEST;
        end
      end
      WARP_REQUEST: state_d = WARP_WAIT;
      WARP_WAIT: begin
        if (!mem_pending) state_d = WARP_EXECUTE;
      end
      WARP_EXECUTE: state_d = WARP_UPDATE;
      WARP_UPDATE:  rotate  = 1'b1;
      default:      state_d = WARP_IDLE;
    endcase

    // Rotation goes straight to the next FETCH, so there is no bubble between warps.
    if (rotate) begin
      pick = rotate_pick(fin_d, cur_q);
      if (pick[WARP_ID_W]) begin
        state_d = WARP_FETCH;
        cur_d   = pick[WARP_ID_W-1:0];
      end else begin
        state_d = WARP_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    enable_d = '0;
    if (state_d != WARP_IDLE && state_d != WARP_DONE) enable_d = NUM_WARPS'(1) << cur_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WARP_IDLE;
      cur_q    <= '0;
      fin_q    <= '1;
      enable_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      fin_q    <= fin_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign warp_state  = state_q;
  assign cur_warp    = cur_q;
  assign warp_enable = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef WARP_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_instr_q;
  logic        accept_start;

  assign accept_start = start && !busy_q;

  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      perf_cycles_q <= '0;
      perf_instr_q  <= '0;
    end else begin
      if (busy_q) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (state_q == WARP_UPDATE) perf_instr_q <= perf_instr_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_instr  = perf_instr_q;
`endif

endmodule
